// File: rtl/cpu_io_pkg.sv
`default_nettype none
// cpu_io_pkg -- IO-bus register map for the display peripherals and the seven-segment glyph table. Rev 1.0
package cpu_io_pkg;

  localparam logic [1:0] SEG_DATA_LO = 2'd0;
  localparam logic [1:0] SEG_DATA_HI = 2'd1;
  localparam logic [1:0] SEG_CTRL    = 2'd2;
  localparam logic [1:0] SEG_DP      = 2'd3;

  localparam int SEG_CTRL_BLANK_BIT = 8;
  localparam int SEG_CTRL_FORCE_BIT = 9;

  // Active-low glyphs {g,f,e,d,c,b,a} for 0..F
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_TABLE[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// seg7_hex_decode -- 4-bit value to active-low seven-segment glyph. Rev 1.0
module seg7_hex_decode
  import cpu_io_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// seg7_scan -- memory-mapped 8-digit multiplexed seven-segment controller with
// double-buffered hex value and inter-digit blanking. Rev 1.0
module seg7_scan
  import cpu_io_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IOWrite,
  input  logic        SegCtrl,
  input  logic [1:0]  seg_addr,
  input  logic [15:0] seg_wdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic        frame_tick
);

  localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   BLANK_END = PW'(BLANK_CYCLES);

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [31:0]   shadow_q;
  logic [31:0]   active_q;
  logic [7:0]    mask_q;
  logic [7:0]    dp_q;
  logic          blank_q;
  logic          force_q;
  logic [7:0]    seg_en_q;
  logic [7:0]    seg_out_q;
  logic          tick_q;

  logic          wr_en;
  logic          frame_end;
  logic          commit;
  logic          dark;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [7:0]    seg_en_d;
  logic [7:0]    seg_out_d;
  logic          wdata_unused;

  assign wr_en        = IOWrite & SegCtrl;
  assign frame_end    = (idx_q == 3'd7) && (presc_q == PRESC_MAX);
  // A pending force_commit and a frame end in the same cycle merge into one commit.
  assign commit       = frame_end | force_q;
  assign nibble       = active_q[{idx_q, 2'b00} +: 4];
  assign dark         = (presc_q < BLANK_END) || blank_q || !mask_q[idx_q];
  assign wdata_unused = ^seg_wdata[15:10];

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    seg_en_d  = 8'hFF;
    seg_out_d = 8'hFF;
    if (!dark) begin
      seg_en_d  = ~(8'd1 << idx_q);
      seg_out_d = {~dp_q[idx_q], glyph};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      idx_q     <= 3'd0;
      shadow_q  <= 32'd0;
      active_q  <= 32'd0;
      mask_q    <= 8'd0;
      dp_q      <= 8'd0;
      blank_q   <= 1'b1;
      force_q   <= 1'b0;
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
        idx_q   <= idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      force_q <= 1'b0;
      if (wr_en) begin
        case (seg_addr)
          SEG_DATA_LO: shadow_q[15:0]  <= seg_wdata;
          SEG_DATA_HI: shadow_q[31:16] <= seg_wdata;
          SEG_CTRL: begin
            mask_q  <= seg_wdata[7:0];
            blank_q <= seg_wdata[SEG_CTRL_BLANK_BIT];
            force_q <= seg_wdata[SEG_CTRL_FORCE_BIT];
          end
          SEG_DP:      dp_q <= seg_wdata[7:0];
          default: ;
        endcase
      end

      // Non-blocking copy: a same-cycle data write lands in shadow only.
      if (commit) active_q <= shadow_q;
      tick_q    <= commit;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_en     = seg_en_q;
  assign seg_out    = seg_out_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// tb_seg7_scan -- self-checking bench: cycle reference model, directed scenarios, glyph table, random traffic. Rev 1.0
module tb_seg7_scan;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IOWrite = 1'b0;
  logic        SegCtrl = 1'b0;
  logic [1:0]  seg_addr = 2'd0;
  logic [15:0] seg_wdata = 16'd0;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_tick;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clock      (clock),
    .reset      (reset),
    .IOWrite    (IOWrite),
    .SegCtrl    (SegCtrl),
    .seg_addr   (seg_addr),
    .seg_wdata  (seg_wdata),
    .seg_en     (seg_en),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] seg;
  } hex_vec_t;

  hex_vec_t vecs [16];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since reset is m_n cycles; slot position is plain arithmetic on it.
  int          m_n;
  int          m_ticks;
  logic [31:0] m_sh, m_act;
  logic [7:0]  m_mask, m_dp, m_en, m_out;
  logic        m_blank, m_pend, m_tick;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, m_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_sh = 0; m_act = 0; m_mask = 0; m_dp = 0;
    m_blank = 1'b1; m_pend = 1'b0;
    m_en = 8'hFF; m_out = 8'hFF; m_tick = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic [1:0] a, input logic [15:0] d);
    int  presc, idx, nib;
    bit  dk, cm;
    presc = m_n % SD;
    idx   = (m_n / SD) % 8;
    nib   = int'((m_act >> (4 * idx)) & 32'hF);
    dk    = (presc < BC) || m_blank || !m_mask[idx];
    m_en  = dk ? 8'hFF : ~(8'h01 << idx);
    m_out = dk ? 8'hFF : {~m_dp[idx], vecs[nib].seg[6:0]};
    cm    = ((m_n % FRAME) == FRAME - 1) || m_pend;
    if (cm) m_act = m_sh;
    m_tick = cm;
    m_pend = 1'b0;
    if (wr) begin
      case (a)
        2'd0: m_sh[15:0]  = d;
        2'd1: m_sh[31:16] = d;
        2'd2: begin m_mask = d[7:0]; m_blank = d[8]; m_pend = d[9]; end
        default: m_dp = d[7:0];
      endcase
    end
    m_n++;
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model.
  task automatic cycle(input logic ce, input logic io, input logic [1:0] a, input logic [15:0] d);
    chk("seg_en", {24'd0, seg_en}, {24'd0, m_en});
    chk("seg_out", {24'd0, seg_out}, {24'd0, m_out});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
    if (frame_tick) m_ticks++;
    SegCtrl = ce; IOWrite = io; seg_addr = a; seg_wdata = d;
    model_step(ce & io, a, d);
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic run_to(input int r);
    for (int i = 0; i < FRAME + 2 && (m_n % FRAME) != r; i++) idle();
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      if (frame_tick) got = 1;
      else idle();
    end
    chk("wait_frame_tick", {31'd0, got}, 32'd1);
  endtask

  initial begin
    vecs = '{
      '{4'h0, 8'hC0}, '{4'h1, 8'hF9}, '{4'h2, 8'hA4}, '{4'h3, 8'hB0},
      '{4'h4, 8'h99}, '{4'h5, 8'h92}, '{4'h6, 8'h82}, '{4'h7, 8'hF8},
      '{4'h8, 8'h80}, '{4'h9, 8'h90}, '{4'hA, 8'h88}, '{4'hB, 8'h83},
      '{4'hC, 8'hC6}, '{4'hD, 8'hA1}, '{4'hE, 8'h86}, '{4'hF, 8'h8E}
    };
    model_reset();
    m_ticks = 0;

    // Reset state, then asynchronous reset in the middle of a lit scan
    repeat (2) @(negedge clock);
    chk("rst_seg_en", {24'd0, seg_en}, 32'hFF);
    chk("rst_seg_out", {24'd0, seg_out}, 32'hFF);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 1'b1;
    wr(2'd2, 16'h00FF);
    repeat (20) idle();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_en", {24'd0, seg_en}, 32'hFF);
    chk("async_rst_out", {24'd0, seg_out}, 32'hFF);
    chk("async_rst_tick", {31'd0, frame_tick}, 32'd0);
    repeat (3) @(negedge clock);
    chk("hold_rst_en", {24'd0, seg_en}, 32'hFF);
    reset = 1'b1;
    model_reset();
    repeat (100) idle();
    chk("dark_after_rst", {24'd0, seg_en}, 32'hFF);

    // Load 0x12345678 and wait for the frame-end commit
    wr(2'd0, 16'h5678);
    wr(2'd1, 16'h1234);
    wr(2'd2, 16'h00FF);
    wait_tick();
    run_to(1); chk("blank0_en", {24'd0, seg_en}, 32'hFF);
    run_to(2); chk("blank1_en", {24'd0, seg_en}, 32'hFF);
    run_to(3);
    chk("d0_en", {24'd0, seg_en}, 32'hFE);
    chk("d0_out", {24'd0, seg_out}, 32'h80);
    run_to(59);
    chk("d7_en", {24'd0, seg_en}, 32'h7F);
    chk("d7_out", {24'd0, seg_out}, 32'hF9);

    // Mid-frame shadow write is invisible until frame end
    run_to(10);
    wr(2'd0, 16'hAAAA);
    run_to(19); chk("d2_old_out", {24'd0, seg_out}, 32'h82);
    run_to(3);  chk("d0_new_out", {24'd0, seg_out}, 32'h88);

    // Write in the exact frame-end cycle
    run_to(FRAME - 1);
    wr(2'd0, 16'h1111);
    m_ticks = 0;
    idle();
    run_to(0);
    chk("ticks_per_frame", m_ticks, 32'd1);
    run_to(3); chk("fe_write_new_out", {24'd0, seg_out}, 32'hF9);

    // Sparse mask and decimal point
    run_to(10);
    wr(2'd3, 16'h0001);
    wr(2'd2, 16'h0005);
    run_to(3);
    chk("m_d0_en", {24'd0, seg_en}, 32'hFE);
    chk("m_d0_dp", {31'd0, seg_out[7]}, 32'd0);
    run_to(11); chk("m_d1_dark", {24'd0, seg_en}, 32'hFF);
    run_to(19); chk("m_d2_en", {24'd0, seg_en}, 32'hFB);
    run_to(27); chk("m_d3_dark", {24'd0, seg_en}, 32'hFF);

    // force_commit latency and ignored writes
    run_to(30);
    wr(2'd2, 16'h0205);
    chk("fc_tick_early", {31'd0, frame_tick}, 32'd0);
    idle();
    chk("fc_tick", {31'd0, frame_tick}, 32'd1);
    idle();
    chk("fc_tick_clear", {31'd0, frame_tick}, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 16'hFFFF);
    cycle(1'b0, 1'b1, 2'd2, 16'h0100);
    cycle(1'b1, 1'b0, 2'd2, 16'h0300);
    wr(2'd2, 16'h0205);
    run_to(3);
    chk("nocs_en", {24'd0, seg_en}, 32'hFE);
    chk("nocs_out", {24'd0, seg_out}, 32'h79);

    // Glyph table through digit 0
    wr(2'd3, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      run_to(10);
      wr(2'd0, {4{vecs[k].nib}});
      wr(2'd2, 16'h02FF);
      run_to(3);
      chk($sformatf("glyph_%h", vecs[k].nib), {24'd0, seg_out}, {24'd0, vecs[k].seg});
    end

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      logic [1:0]  a;
      d = 16'($urandom);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd2) begin
        d[8] = ($urandom_range(0, 3) == 0);
        d[9] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 2) == 0)
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, d);
      else
        idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
